// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values, Status/Cause
// field positions and the per-cycle control action encoding.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_IE_BIT     = 0;
    localparam int STATUS_IM_LO      = 8;
    localparam int STATUS_IM_HI      = 15;
    localparam int STATUS_PUSH_SHIFT = 5;

    localparam int CAUSE_OVF_BIT = 31;
    localparam int CAUSE_TI_BIT  = 30;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_SW_HI   = 9;
    localparam int CAUSE_SW_LO   = 8;
    localparam int CAUSE_HW_LO   = 10;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_EXC_LO  = 2;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_ENTRY,
        ACT_ERET,
        ACT_DROP
    } cp0_act_e;

    // An interrupt is requested when IE is set and any pending line is unmasked.
    function automatic logic int_request(input logic [31:0] status, input logic [7:0] pending);
        return status[STATUS_IE_BIT] & (|(pending & status[STATUS_IM_HI:STATUS_IM_LO]));
    endfunction

endpackage

// File: rtl/cp0_save_stack.sv
// LIFO holding the {Status, EPC} context of each nested exception level.
module cp0_save_stack
    import cp0_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic [3:0]       o_level,
    output logic             o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [3:0]       r_level;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_push_idx;

    assign w_top_idx  = AW'(r_level - 4'd1);
    assign w_push_idx = AW'(r_level);
    assign o_level    = r_level;
    assign o_full     = (r_level == 4'(DEPTH));
    assign o_top      = (r_level != 4'd0) ? r_mem[w_top_idx] : '0;

    // Push stores at the current level and grows; pop only shrinks the level.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_level <= 4'd0;
        end else if (i_push && !o_full) begin
            r_mem[w_push_idx] <= i_data;
            r_level           <= r_level + 4'd1;
        end else if (i_pop && (r_level != 4'd0)) begin
            r_level <= r_level - 4'd1;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: Status/Cause/EPC, nested exception entry/return
// with a save stack, and mfc0/mtc0 access. Defining CP0_TIMER_EN adds the
// Count/Compare timer and its TI interrupt.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          NEST_DEPTH = 2,
    parameter int          IRQ_W      = 6,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004,
    parameter logic [31:0] STATUS_RST = 32'h0000000F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mfc0,
    input  logic             mtc0,
    input  logic [4:0]       addr,
    input  logic [31:0]      wdata,
    input  logic [31:0]      pc,
    input  logic             exc_req,
    input  logic [4:0]       exc_code,
    input  logic             eret,
    input  logic [IRQ_W-1:0] irq,
    output logic [31:0]      rdata,
    output logic [31:0]      status,
    output logic [31:0]      epc,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [3:0]       nest_lvl
);

    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_rdata;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;

    logic [63:0] w_top;
    logic [3:0]  w_level;
    logic        w_full;
    logic [7:0]  w_irq_ext;
    logic        w_int_req;
    cp0_act_e    w_act;
    logic [4:0]  w_code;
    logic        w_busy;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_ti_next;
    logic [31:0] w_read;

    assign w_irq_ext   = 8'(irq);
    assign w_int_req   = int_request(r_status, r_cause[CAUSE_IP_HI:CAUSE_IP_LO]);
    assign w_busy      = (w_act == ACT_ENTRY) || (w_act == ACT_ERET);
    assign w_wr_status = mtc0 && (addr == REG_STATUS) && !w_busy;
    assign w_wr_cause  = mtc0 && (addr == REG_CAUSE) && !w_busy;
    assign w_wr_epc    = mtc0 && (addr == REG_EPC) && !w_busy;

    // Arbitrate the cycle's control action: exception, then eret, then interrupt.
    always_comb begin
        w_act  = ACT_NONE;
        w_code = EXC_INT;
        if (exc_req) begin
            w_act  = w_full ? ACT_DROP : ACT_ENTRY;
            w_code = exc_code;
        end else if (eret) begin
            if (w_level != 4'd0) begin
                w_act = ACT_ERET;
            end
        end else if (w_int_req) begin
            w_act = w_full ? ACT_DROP : ACT_ENTRY;
        end
    end

    cp0_save_stack #(
        .DEPTH (NEST_DEPTH),
        .WIDTH (64)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_act == ACT_ENTRY),
        .i_pop   (w_act == ACT_ERET),
        .i_data  ({r_status, r_epc}),
        .o_top   (w_top),
        .o_level (w_level),
        .o_full  (w_full)
    );

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        w_wr_count;
    logic        w_wr_compare;

    assign w_wr_count   = mtc0 && (addr == REG_COUNT);
    assign w_wr_compare = mtc0 && (addr == REG_COMPARE);

    // Count free-runs every cycle; software may reload Count or Compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'hFFFFFFFF;
        end else begin
            r_count <= w_wr_count ? wdata : r_count + 32'd1;
            if (w_wr_compare) begin
                r_compare <= wdata;
            end
        end
    end

    // TI latches on a Count/Compare match and is cleared by writing Compare.
    always_comb begin
        w_ti_next = r_cause[CAUSE_TI_BIT];
        if (r_count == r_compare) begin
            w_ti_next = 1'b1;
        end
        if (w_wr_compare) begin
            w_ti_next = 1'b0;
        end
    end
`else
    assign w_ti_next = 1'b0;
`endif

    // mfc0 source select; unimplemented registers read as zero.
    always_comb begin
        w_read = '0;
        case (addr)
            REG_STATUS:  w_read = r_status;
            REG_CAUSE:   w_read = r_cause;
            REG_EPC:     w_read = r_epc;
`ifdef CP0_TIMER_EN
            REG_COUNT:   w_read = r_count;
            REG_COMPARE: w_read = r_compare;
`endif
            default:     w_read = '0;
        endcase
    end

    // Status and EPC follow entry/return first, software writes otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= STATUS_RST;
            r_epc    <= 32'd0;
        end else begin
            case (w_act)
                ACT_ENTRY: begin
                    r_status <= r_status << STATUS_PUSH_SHIFT;
                    r_epc    <= pc;
                end
                ACT_ERET: begin
                    r_status <= w_top[63:32];
                    r_epc    <= w_top[31:0];
                end
                default: begin
                    if (w_wr_status) begin
                        r_status <= wdata;
                    end
                    if (w_wr_epc) begin
                        r_epc <= wdata;
                    end
                end
            endcase
        end
    end

    // Cause: sticky overflow, timer flag, sampled lines, sw bits, ExcCode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cause <= 32'd0;
        end else begin
            if (w_act == ACT_DROP) begin
                r_cause[CAUSE_OVF_BIT] <= 1'b1;
            end else if (w_wr_cause) begin
                r_cause[CAUSE_OVF_BIT] <= 1'b0;
            end
            r_cause[CAUSE_TI_BIT]        <= w_ti_next;
            r_cause[CAUSE_HW_LO +: 8]    <= w_irq_ext | (8'(w_ti_next) << 5);
            if (w_wr_cause) begin
                r_cause[CAUSE_SW_HI:CAUSE_SW_LO] <= wdata[CAUSE_SW_HI:CAUSE_SW_LO];
            end
            if (w_act == ACT_ENTRY) begin
                r_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] <= w_code;
            end
        end
    end

    // Redirect is a one-cycle pulse; the target is held between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= EXC_VECTOR;
        end else begin
            r_redirect <= w_busy;
            if (w_act == ACT_ENTRY) begin
                r_redirect_pc <= EXC_VECTOR;
            end else if (w_act == ACT_ERET) begin
                r_redirect_pc <= r_epc;
            end
        end
    end

    // mfc0 result is captured on the strobe and held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else if (mfc0) begin
            r_rdata <= w_read;
        end
    end

    assign rdata       = r_rdata;
    assign status      = r_status;
    assign epc         = r_epc;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign nest_lvl    = w_level;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: table of per-cycle vectors plus
// hand-written reset and timer sequences (timer part follows CP0_TIMER_EN).
module tb_cp0_exc_ctrl;
    import cp0_pkg::*;

    localparam logic [31:0] VEC = 32'h00400004;

    typedef struct {
        logic        mfc0;
        logic        mtc0;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        exc_req;
        logic [4:0]  exc_code;
        logic        eret;
        logic [5:0]  irq;
        logic        exp_redirect;
        logic [31:0] exp_rpc;
        logic [3:0]  exp_nest;
        logic [31:0] exp_status;
        logic [31:0] exp_epc;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, mfc0, mtc0, exc_req, eret;
    logic [4:0]  addr, exc_code;
    logic [31:0] wdata, pc;
    logic [5:0]  irq;
    logic [31:0] rdata, status, epc, redirect_pc;
    logic        redirect;
    logic [3:0]  nest_lvl;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cp0_exc_ctrl #(
        .NEST_DEPTH (2),
        .IRQ_W      (6),
        .EXC_VECTOR (VEC),
        .STATUS_RST (32'h0000000F)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mfc0        (mfc0),
        .mtc0        (mtc0),
        .addr        (addr),
        .wdata       (wdata),
        .pc          (pc),
        .exc_req     (exc_req),
        .exc_code    (exc_code),
        .eret        (eret),
        .irq         (irq),
        .rdata       (rdata),
        .status      (status),
        .epc         (epc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .nest_lvl    (nest_lvl)
    );

    function automatic vec_t makeVec(
        input logic mf, input logic mt, input logic [4:0] a, input logic [31:0] wd,
        input logic [31:0] p, input logic er, input logic [4:0] ec, input logic et,
        input logic [5:0] iq, input logic xr, input logic [31:0] xrpc, input logic [3:0] xn,
        input logic [31:0] xs, input logic [31:0] xe, input logic cr, input logic [31:0] xrd);
        vec_t v;
        v.mfc0 = mf; v.mtc0 = mt; v.addr = a; v.wdata = wd; v.pc = p;
        v.exc_req = er; v.exc_code = ec; v.eret = et; v.irq = iq;
        v.exp_redirect = xr; v.exp_rpc = xrpc; v.exp_nest = xn;
        v.exp_status = xs; v.exp_epc = xe; v.chk_rdata = cr; v.exp_rdata = xrd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        mfc0 = 0; mtc0 = 0; addr = '0; wdata = '0; pc = '0;
        exc_req = 0; exc_code = '0; eret = 0; irq = '0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        mfc0 = v.mfc0; mtc0 = v.mtc0; addr = v.addr; wdata = v.wdata; pc = v.pc;
        exc_req = v.exc_req; exc_code = v.exc_code; eret = v.eret; irq = v.irq;
        tick();
    endtask

    task automatic readReg(input logic [4:0] a);
        clearInputs();
        mfc0 = 1; addr = a;
        tick();
        clearInputs();
    endtask

    task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
        clearInputs();
        mtc0 = 1; addr = a; wdata = d;
        tick();
        clearInputs();
    endtask

    initial begin
        logic [31:0] exp_count0, exp_compare, exp_cause_ti;
`ifdef CP0_TIMER_EN
        exp_count0   = 32'd0;
        exp_compare  = 32'd5;
        exp_cause_ti = 32'h40008000;
`else
        exp_count0   = 32'd0;
        exp_compare  = 32'd0;
        exp_cause_ti = 32'd0;
`endif
        //                 mf mt addr        wdata         pc            er ec        et irq   xr xrpc          xn  xstatus       xepc          cr xrdata
        vecs.push_back(makeVec(1, 0, REG_STATUS, 32'h0,        32'h0,        0, EXC_INT,  0, 6'h0, 0, VEC,          0,  32'h0000000F, 32'h0,        1, 32'h0000000F));
        vecs.push_back(makeVec(0, 0, 5'd0,       32'h0,        32'h00400100, 1, EXC_SYS,  0, 6'h0, 1, VEC,          1,  32'h000001E0, 32'h00400100, 0, 32'h0));
        vecs.push_back(makeVec(1, 0, REG_CAUSE,  32'h0,        32'h0,        0, EXC_INT,  0, 6'h0, 0, VEC,          1,  32'h000001E0, 32'h00400100, 1, 32'h00000020));
        vecs.push_back(makeVec(0, 0, 5'd0,       32'h0,        32'h00400200, 1, EXC_RI,   0, 6'h0, 1, VEC,          2,  32'h00003C00, 32'h00400200, 0, 32'h0));
        vecs.push_back(makeVec(0, 0, 5'd0,       32'h0,        32'h00400300, 1, EXC_OV,   0, 6'h0, 0, VEC,          2,  32'h00003C00, 32'h00400200, 0, 32'h0));
        vecs.push_back(makeVec(1, 0, REG_CAUSE,  32'h0,        32'h0,        0, EXC_INT,  0, 6'h0, 0, VEC,          2,  32'h00003C00, 32'h00400200, 1, 32'h80000028));
        vecs.push_back(makeVec(0, 0, 5'd0,       32'h0,        32'h0,        0, EXC_INT,  1, 6'h0, 1, 32'h00400200, 1,  32'h000001E0, 32'h00400100, 0, 32'h0));
        vecs.push_back(makeVec(0, 0, 5'd0,       32'h0,        32'h0,        0, EXC_INT,  1, 6'h0, 1, 32'h00400100, 0,  32'h0000000F, 32'h0,        0, 32'h0));
        vecs.push_back(makeVec(0, 0, 5'd0,       32'h0,        32'h0,        0, EXC_INT,  1, 6'h0, 0, 32'h00400100, 0,  32'h0000000F, 32'h0,        0, 32'h0));
        vecs.push_back(makeVec(0, 1, REG_CAUSE,  32'h00000100, 32'h0,        0, EXC_INT,  0, 6'h0, 0, 32'h00400100, 0,  32'h0000000F, 32'h0,        1, 32'h80000028));
        vecs.push_back(makeVec(1, 0, REG_CAUSE,  32'h0,        32'h0,        0, EXC_INT,  0, 6'h0, 0, 32'h00400100, 0,  32'h0000000F, 32'h0,        1, 32'h00000128));
        vecs.push_back(makeVec(0, 1, REG_CAUSE,  32'hFFFFFCFF, 32'h0,        0, EXC_INT,  0, 6'h0, 0, 32'h00400100, 0,  32'h0000000F, 32'h0,        0, 32'h0));
        vecs.push_back(makeVec(1, 0, REG_CAUSE,  32'h0,        32'h0,        0, EXC_INT,  0, 6'h0, 0, 32'h00400100, 0,  32'h0000000F, 32'h0,        1, 32'h00000028));
        vecs.push_back(makeVec(0, 1, 5'd20,      32'h00000123, 32'h0,        0, EXC_INT,  0, 6'h0, 0, 32'h00400100, 0,  32'h0000000F, 32'h0,        0, 32'h0));
        vecs.push_back(makeVec(1, 0, 5'd20,      32'h0,        32'h0,        0, EXC_INT,  0, 6'h0, 0, 32'h00400100, 0,  32'h0000000F, 32'h0,        1, 32'h0));
        vecs.push_back(makeVec(0, 1, REG_EPC,    32'h00401000, 32'h0,        0, EXC_INT,  0, 6'h0, 0, 32'h00400100, 0,  32'h0000000F, 32'h00401000, 0, 32'h0));
        vecs.push_back(makeVec(0, 1, REG_STATUS, 32'h00000401, 32'h0,        0, EXC_INT,  0, 6'h1, 0, 32'h00400100, 0,  32'h00000401, 32'h00401000, 0, 32'h0));
        vecs.push_back(makeVec(0, 0, 5'd0,       32'h0,        32'h00400500, 0, EXC_INT,  0, 6'h1, 1, VEC,          1,  32'h00008020, 32'h00400500, 0, 32'h0));
        vecs.push_back(makeVec(1, 0, REG_CAUSE,  32'h0,        32'h0,        0, EXC_INT,  0, 6'h1, 0, VEC,          1,  32'h00008020, 32'h00400500, 1, 32'h00000400));
        vecs.push_back(makeVec(0, 0, 5'd0,       32'h0,        32'h00400600, 1, EXC_ADEL, 1, 6'h0, 1, VEC,          2,  32'h00100400, 32'h00400600, 0, 32'h0));
        vecs.push_back(makeVec(0, 1, REG_STATUS, 32'h12345678, 32'h0,        0, EXC_INT,  1, 6'h0, 1, 32'h00400600, 1,  32'h00008020, 32'h00400500, 0, 32'h0));
        vecs.push_back(makeVec(0, 1, REG_EPC,    32'hDEAD0000, 32'h00400700, 1, EXC_TLBL, 0, 6'h0, 1, VEC,          2,  32'h00100400, 32'h00400700, 0, 32'h0));
        vecs.push_back(makeVec(1, 0, REG_CAUSE,  32'h0,        32'h0,        0, EXC_INT,  0, 6'h0, 0, VEC,          2,  32'h00100400, 32'h00400700, 1, 32'h00000008));

        clearInputs();
        reset = 1;
        tick();
        tick();
        reset = 0;

        checkOutput("reset.status",   status,               32'h0000000F);
        checkOutput("reset.epc",      epc,                  32'h0);
        checkOutput("reset.nest",     {28'd0, nest_lvl},    32'd0);
        checkOutput("reset.redirect", {31'd0, redirect},    32'd0);
        checkOutput("reset.rpc",      redirect_pc,          VEC);
        checkOutput("reset.rdata",    rdata,                32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d.redirect", i), {31'd0, redirect}, {31'd0, vecs[i].exp_redirect});
            checkOutput($sformatf("v%0d.rpc", i),      redirect_pc,       vecs[i].exp_rpc);
            checkOutput($sformatf("v%0d.nest", i),     {28'd0, nest_lvl}, {28'd0, vecs[i].exp_nest});
            checkOutput($sformatf("v%0d.status", i),   status,            vecs[i].exp_status);
            checkOutput($sformatf("v%0d.epc", i),      epc,               vecs[i].exp_epc);
            if (vecs[i].chk_rdata) begin
                checkOutput($sformatf("v%0d.rdata", i), rdata, vecs[i].exp_rdata);
            end
        end
        clearInputs();

        // Reset mid-nest with competing strobes.
        reset = 1; eret = 1; exc_req = 1; mtc0 = 1; addr = REG_STATUS; wdata = 32'hFFFFFFFF;
        tick();
        clearInputs();
        reset = 0;
        checkOutput("midrst.status",   status,            32'h0000000F);
        checkOutput("midrst.epc",      epc,               32'h0);
        checkOutput("midrst.nest",     {28'd0, nest_lvl}, 32'd0);
        checkOutput("midrst.redirect", {31'd0, redirect}, 32'd0);
        checkOutput("midrst.rpc",      redirect_pc,       VEC);
        checkOutput("midrst.rdata",    rdata,             32'h0);
        eret = 1;
        tick();
        clearInputs();
        checkOutput("midrst.eret_redirect", {31'd0, redirect}, 32'd0);
        checkOutput("midrst.eret_nest",     {28'd0, nest_lvl}, 32'd0);
        readReg(REG_CAUSE);
        checkOutput("midrst.cause", rdata, 32'h0);

        // Timer sequence from a fresh reset.
        reset = 1;
        tick();
        reset = 0;
        readReg(REG_COUNT);
        checkOutput("timer.count0", rdata, exp_count0);
        writeReg(REG_COMPARE, 32'd5);
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        readReg(REG_CAUSE);
        checkOutput("timer.cause_ti", rdata, exp_cause_ti);
        readReg(REG_COMPARE);
        checkOutput("timer.compare", rdata, exp_compare);
        checkOutput("timer.nest", {28'd0, nest_lvl}, 32'd0);
        writeReg(REG_COMPARE, 32'hFFFFFFFF);
        readReg(REG_CAUSE);
        checkOutput("timer.cause_clr", rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 Parameter NEST_DEPTH, default 2: maximum number of nested exceptions held in the save stack (1..8).
REQ-002 Parameter IRQ_W, default 6: number of hardware interrupt lines (1..8).
REQ-003 Parameter EXC_VECTOR, default 32'h00400004: exception handler entry address.
REQ-004 Parameter STATUS_RST, default 32'h0000000F: Status value after reset.
REQ-005 Ports: clk in 1 rising-edge clock; reset in 1 synchronous, active-high; mfc0 in 1 read strobe; mtc0 in 1 write strobe; addr in 5 CP0 register number; wdata in 32 mtc0 data; pc in 32 faulting-instruction PC; exc_req in 1 synchronous exception request; exc_code in 5 ExcCode; eret in 1 return strobe; irq in IRQ_W interrupt lines; rdata out 32 mfc0 result; status out 32 current Status; epc out 32 current EPC; redirect out 1 one-cycle PC redirect pulse; redirect_pc out 32 redirect target; nest_lvl out 4 current depth.

Function
REQ-006 Registers: Status (12), Cause (13), EPC (14), plus Count (9) and Compare (11) under CP0_TIMER_EN; any other addr reads 0, writes ignored.
REQ-007 mfc0: rdata registered, valid one cycle after strobe, holds until next mfc0.
REQ-008 mtc0: target register updated at the clock edge of the strobe; Cause writable only in bits [9:8] (software interrupts).
REQ-009 Cause[15:8] pending = {sw[1:0], irq} right-aligned, irq sampled every cycle into Cause[8+2+IRQ_W-1:10]; bits above held 0.
REQ-010 Interrupt request = Status[0] (IE) & |(Cause[15:8] & Status[15:8]).
REQ-011 Exception entry (exc_req, or interrupt request when exc_req low), accepted only when nest_lvl < NEST_DEPTH: push {Status, EPC} onto stack; Status <= Status << 5; EPC <= pc; Cause[6:2] <= exc_code (0 for interrupt); nest_lvl +1; redirect=1, redirect_pc=EXC_VECTOR next cycle.
REQ-012 Entry when nest_lvl == NEST_DEPTH: request dropped, state unchanged, Cause[31] (overflow) set sticky until mtc0 to Cause or reset.
REQ-013 eret with nest_lvl > 0: redirect=1, redirect_pc = EPC; Status and EPC restored from top of stack; nest_lvl -1.
REQ-014 eret with nest_lvl == 0: no-op, no redirect.
REQ-015 Priority same cycle: exc_req > eret > interrupt > mtc0; a lower-priority mtc0 to Status/EPC/Cause is discarded when entry or eret fires.
REQ-016 redirect is a single-cycle pulse; at most one per cycle.

Reset
REQ-017 On reset: Status=STATUS_RST, Cause=0, EPC=0, stack cleared, nest_lvl=0, rdata=0, redirect=0, redirect_pc=EXC_VECTOR, Count=0, Compare=32'hFFFFFFFF.
REQ-018 Reset overrides all strobes in the same cycle, including mid-nest.

Configuration
REQ-019 Macro CP0_TIMER_EN defined: Count increments every cycle (wraps at 2^32); Count==Compare sets Cause[30] (TI), ORed into Cause[15] pending; mtc0 to Compare clears TI.
REQ-020 Macro undefined: no Count/Compare storage, addrs 9/11 read 0, Cause[30] stays 0.

Structure
REQ-021 Shared package cp0_pkg: register-number constants, ExcCode constants, Status/Cause field-position constants.
REQ-022 Sub-module cp0_save_stack: parametrised LIFO of 64-bit {Status, EPC} entries, push/pop/level/full.

Verification
REQ-023 Reset then mfc0 addr 12 -> rdata=32'h0000000F next cycle; nest_lvl=0.
REQ-024 exc_req, pc=32'h00400100, exc_code=8 -> redirect, redirect_pc=32'h00400004; EPC=32'h00400100; Status=32'h000001E0; Cause[6:2]=8.
REQ-025 Two nested exc_req then third (NEST_DEPTH=2) -> third dropped, Cause[31]=1; two eret restore EPC/Status in LIFO order, nest_lvl 2->1->0.
REQ-026 Status=32'h00000401, irq[0]=1 -> interrupt entry, Cause[6:2]=0, Cause[10]=1.
REQ-027 exc_req and eret same cycle at nest_lvl=1 -> entry taken, nest_lvl=2, redirect_pc=EXC_VECTOR.
REQ-028 CP0_TIMER_EN, Compare=5 after reset -> Cause[30]=1 when Count reaches 5; mtc0 Compare clears it.
